// File: rtl/spi_flash_arbiter_if.sv
// One rstrb/rbusy/rdata word-read port. The master issues reads; the slave answers them.
interface spi_flash_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 20
);
    logic [ADDR_WIDTH-1:0] word_address;
    logic                  rstrb;
    logic [31:0]           rdata;
    logic                  rbusy;

    modport master (
        output word_address,
        output rstrb,
        input  rdata,
        input  rbusy
    );

    modport slave (
        input  word_address,
        input  rstrb,
        output rdata,
        output rbusy
    );
endinterface

// File: rtl/spi_flash_arbiter.sv
// Round-robin arbiter sharing one SPI flash read port between two requesters,
// with a one-word last-read buffer in front of the flash.
module spi_flash_arbiter #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter bit          USE_BUF    = 1'b1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                inval,
    spi_flash_arbiter_if.slave  m0,
    spi_flash_arbiter_if.slave  m1,
    spi_flash_arbiter_if.master s
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    state_e                r_state;
    logic [1:0]            r_pend;
    logic [ADDR_WIDTH-1:0] r_addr0;
    logic [ADDR_WIDTH-1:0] r_addr1;
    logic [ADDR_WIDTH-1:0] r_s_addr;
    logic [31:0]           r_rdata0;
    logic [31:0]           r_rdata1;
    logic                  r_grant;
    logic                  r_last_grant;
    logic                  r_buf_valid;
    logic [ADDR_WIDTH-1:0] r_buf_addr;
    logic [31:0]           r_buf_data;

    logic                  w_winner;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic                  w_hit;
    logic                  w_serve_hit;
    logic                  w_done;
    logic [1:0]            w_clr;

    always_comb begin
        // On a tie the requester that was not granted last time wins.
        w_winner    = r_pend[1] & (~r_pend[0] | ~r_last_grant);
        w_win_addr  = w_winner ? r_addr1 : r_addr0;
        w_hit       = USE_BUF && r_buf_valid && (w_win_addr == r_buf_addr);
        w_serve_hit = (r_state == StIdle) && (r_pend != 2'b00) && w_hit;
        w_done      = (r_state == StWait) && !s.rbusy;
        w_clr       = 2'b00;
        if (w_serve_hit) begin
            w_clr[w_winner] = 1'b1;
        end
        if (w_done) begin
            w_clr[r_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= StIdle;
            r_pend       <= 2'b00;
            r_addr0      <= '0;
            r_addr1      <= '0;
            r_s_addr     <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_buf_valid  <= 1'b0;
            r_buf_addr   <= '0;
            r_buf_data   <= '0;
        end else begin
            // A new strobe beats a completion on the same edge.
            r_pend <= (r_pend & ~w_clr) | {m1.rstrb, m0.rstrb};
            if (m0.rstrb) begin
                r_addr0 <= m0.word_address;
            end
            if (m1.rstrb) begin
                r_addr1 <= m1.word_address;
            end

            case (r_state)
                StIdle: begin
                    if (r_pend != 2'b00) begin
                        r_last_grant <= w_winner;
                        if (w_hit) begin
                            if (w_winner) begin
                                r_rdata1 <= r_buf_data;
                            end else begin
                                r_rdata0 <= r_buf_data;
                            end
                        end else begin
                            r_grant  <= w_winner;
                            r_s_addr <= w_win_addr;
                            r_state  <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    r_state <= StWait;
                end
                StWait: begin
                    if (!s.rbusy) begin
                        if (r_grant) begin
                            r_rdata1 <= s.rdata;
                        end else begin
                            r_rdata0 <= s.rdata;
                        end
                        r_buf_addr <= r_s_addr;
                        r_buf_data <= s.rdata;
                        r_state    <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase

            // Invalidate beats a same-edge fill.
            if (inval) begin
                r_buf_valid <= 1'b0;
            end else if (w_done) begin
                r_buf_valid <= 1'b1;
            end
        end
    end

    assign m0.rdata       = r_rdata0;
    assign m0.rbusy       = r_pend[0];
    assign m1.rdata       = r_rdata1;
    assign m1.rbusy       = r_pend[1];
    assign s.word_address = r_s_addr;
    assign s.rstrb        = (r_state == StIssue);

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter: a small flash responder plus hand-computed expectations.
module tb_spi_flash_arbiter;

    localparam int unsigned AW = 20;

    logic clk = 1'b0;
    logic resetn;
    logic inval;

    always #5 clk = ~clk;

    spi_flash_arbiter_if #(.ADDR_WIDTH(AW)) m0_if ();
    spi_flash_arbiter_if #(.ADDR_WIDTH(AW)) m1_if ();
    spi_flash_arbiter_if #(.ADDR_WIDTH(AW)) s_if ();

    spi_flash_arbiter #(
        .ADDR_WIDTH(AW),
        .USE_BUF   (1'b1)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .inval (inval),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Flash responder: busy from the cycle after the strobe, drops it flash_lat cycles later.
    int            flash_lat = 3;
    int            busy_cnt  = 0;
    logic [AW-1:0] slog [$];

    function automatic logic [31:0] flash_word(input logic [AW-1:0] a);
        if (a == 20'h00010) return 32'hDEADBEEF;
        return {12'hA50, a};
    endfunction

    initial begin
        s_if.rbusy = 1'b0;
        s_if.rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                busy_cnt   = 0;
                s_if.rbusy = 1'b0;
            end else if (s_if.rstrb) begin
                slog.push_back(s_if.word_address);
                busy_cnt   = flash_lat;
                s_if.rbusy = 1'b1;
                s_if.rdata = 32'h0BAD0BAD;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    s_if.rbusy = 1'b0;
                    s_if.rdata = flash_word(s_if.word_address);
                end
            end
        end
    end

    function automatic logic busy_of(input int n);
        return (n == 0) ? m0_if.rbusy : m1_if.rbusy;
    endfunction

    // Strobe in one cycle; returns at the following negedge with the strobe released.
    task automatic pulse(input logic en0, input logic [AW-1:0] a0,
                         input logic en1, input logic [AW-1:0] a1);
        @(negedge clk);
        m0_if.rstrb        = en0;
        m0_if.word_address = a0;
        m1_if.rstrb        = en1;
        m1_if.word_address = a1;
        @(negedge clk);
        m0_if.rstrb = 1'b0;
        m1_if.rstrb = 1'b0;
    endtask

    task automatic wait_done(input int n, input string tag, output int cyc);
        cyc = 0;
        while (busy_of(n) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (busy_of(n)) check_eq({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic read_req(input int n, input logic [AW-1:0] a, input string tag);
        int cyc;
        if (n == 0) pulse(1'b1, a, 1'b0, '0);
        else        pulse(1'b0, '0, 1'b1, a);
        wait_done(n, tag, cyc);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_m0_rdata"}, m0_if.rdata, 32'h0);
        check_eq({tag, "_m1_rdata"}, m1_if.rdata, 32'h0);
        check_eq({tag, "_busy"}, {30'b0, m1_if.rbusy, m0_if.rbusy}, 32'h0);
        check_eq({tag, "_s_rstrb"}, {31'b0, s_if.rstrb}, 32'h0);
        check_eq({tag, "_s_addr"}, {12'b0, s_if.word_address}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int base;
        resetn             = 1'b0;
        inval              = 1'b0;
        m0_if.rstrb        = 1'b0;
        m0_if.word_address = '0;
        m1_if.rstrb        = 1'b0;
        m1_if.word_address = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        resetn = 1'b1;

        // Single miss, exact timing.
        flash_lat = 5;
        pulse(1'b1, 20'h00010, 1'b0, '0);
        check_eq("t1_rbusy_T1", {31'b0, m0_if.rbusy}, 32'd1);
        check_eq("t1_no_strobe_T1", {31'b0, s_if.rstrb}, 32'd0);
        @(negedge clk);
        check_eq("t1_strobe_T2", {31'b0, s_if.rstrb}, 32'd1);
        check_eq("t1_s_addr", {12'b0, s_if.word_address}, 32'h00010);
        wait_done(0, "t1", cyc);
        check_eq("t1_latency", cyc, 32'd6);
        check_eq("t1_m0_rdata", m0_if.rdata, 32'hDEADBEEF);
        check_eq("t1_m1_rdata", m1_if.rdata, 32'h0);
        check_eq("t1_strobes", slog.size(), 32'd1);

        // Simultaneous strobes after reset: m0 wins the first tie.
        do_reset();
        check_eq("t2_rdata_cleared", m0_if.rdata, 32'h0);
        flash_lat = 3;
        base = slog.size();
        pulse(1'b1, 20'h00100, 1'b1, 20'h00200);
        wait_done(0, "t2_m0", cyc);
        check_eq("t2_m1_still_busy", {31'b0, m1_if.rbusy}, 32'd1);
        check_eq("t2_m0_rdata", m0_if.rdata, 32'hA5000100);
        wait_done(1, "t2_m1", cyc);
        check_eq("t2_m1_rdata", m1_if.rdata, 32'hA5000200);
        check_eq("t2_strobes", slog.size() - base, 32'd2);
        check_eq("t2_first_addr", {12'b0, slog[base]}, 32'h00100);
        check_eq("t2_second_addr", {12'b0, slog[base+1]}, 32'h00200);

        // m0 granted last, so on the next tie m1 goes first.
        read_req(0, 20'h00300, "t3_solo");
        check_eq("t3_solo_m0_rdata", m0_if.rdata, 32'hA5000300);
        check_eq("t3_m1_rdata_kept", m1_if.rdata, 32'hA5000200);
        base = slog.size();
        pulse(1'b1, 20'h00400, 1'b1, 20'h00500);
        wait_done(1, "t3_m1", cyc);
        check_eq("t3_m0_still_busy", {31'b0, m0_if.rbusy}, 32'd1);
        check_eq("t3_m1_rdata", m1_if.rdata, 32'hA5000500);
        wait_done(0, "t3_m0", cyc);
        check_eq("t3_m0_rdata", m0_if.rdata, 32'hA5000400);
        check_eq("t3_first_addr", {12'b0, slog[base]}, 32'h00500);
        check_eq("t3_second_addr", {12'b0, slog[base+1]}, 32'h00400);

        // Back-to-back reread of the same word hits the buffer.
        read_req(1, 20'h00200, "t4_fill");
        base = slog.size();
        pulse(1'b0, '0, 1'b1, 20'h00200);
        check_eq("t4_busy_one_cycle", {31'b0, m1_if.rbusy}, 32'd1);
        @(negedge clk);
        check_eq("t4_busy_dropped", {31'b0, m1_if.rbusy}, 32'd0);
        check_eq("t4_hit_rdata", m1_if.rdata, 32'hA5000200);
        repeat (3) @(negedge clk);
        check_eq("t4_no_flash_access", slog.size() - base, 32'd0);

        // Invalidate, then the same reread goes to the flash.
        @(negedge clk);
        inval = 1'b1;
        @(negedge clk);
        inval = 1'b0;
        base = slog.size();
        read_req(1, 20'h00200, "t5_after_inval");
        check_eq("t5_flash_access", slog.size() - base, 32'd1);
        check_eq("t5_addr", {12'b0, slog[base]}, 32'h00200);

        // Invalidate on the same edge as a fill: next read of that word misses.
        flash_lat = 3;
        pulse(1'b1, 20'h00600, 1'b0, '0);
        repeat (4) @(negedge clk);
        check_eq("t5_fill_pending", {31'b0, m0_if.rbusy}, 32'd1);
        inval = 1'b1;
        @(negedge clk);
        inval = 1'b0;
        check_eq("t5_fill_done", {31'b0, m0_if.rbusy}, 32'd0);
        check_eq("t5_fill_rdata", m0_if.rdata, 32'hA5000600);
        base = slog.size();
        read_req(0, 20'h00600, "t5_reread");
        check_eq("t5_reread_miss", slog.size() - base, 32'd1);
        check_eq("t5_reread_rdata", m0_if.rdata, 32'hA5000600);

        // Reset while waiting on the flash abandons the request.
        flash_lat = 10;
        pulse(1'b1, 20'h00700, 1'b0, '0);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        #1;
        check_outputs_zero("t6_reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("t6_no_delivery", m0_if.rdata, 32'h0);
        check_eq("t6_idle_after", {30'b0, m1_if.rbusy, m0_if.rbusy}, 32'h0);
        flash_lat = 2;
        base = slog.size();
        read_req(1, 20'h00600, "t6_buf_cleared");
        check_eq("t6_buf_miss", slog.size() - base, 32'd1);
        check_eq("t6_m1_rdata", m1_if.rdata, 32'hA5000600);
        read_req(0, 20'h00004, "t6_m0");
        check_eq("t6_m0_addr", {12'b0, slog[base+1]}, 32'h00004);
        check_eq("t6_m0_rdata", m0_if.rdata, 32'hA5000004);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_flash_arbiter.md
# spi_flash_arbiter

Two-port read arbiter that shares one word-addressed SPI flash read port between two requesters: an instruction-fetch master and a data/DMA master. It sits between the requesters and the memory-mapped SPI flash controller, and uses the same rstrb/rbusy/rdata protocol on both sides. It latches single-cycle read strobes, serialises them with round-robin priority, and returns data to the owning requester. A one-word last-read buffer serves repeated reads of the same word without touching the flash.

## Interface
- ADDR_WIDTH, 20: word-address width on all ports.
- USE_BUF, 1: 1 enables the last-read buffer; 0 sends every request to the flash.
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- m0_word_address  in  ADDR_WIDTH  requester 0 word address, sampled when m0_rstrb=1.
- m0_rstrb  in  1  requester 0 read strobe, single-cycle pulse.
- m0_rdata  out  32  requester 0 read data, registered.
- m0_rbusy  out  1  requester 0 request pending or in flight.
- m1_word_address, m1_rstrb, m1_rdata, m1_rbusy: same as the m0 ports, for requester 1.
- inval  in  1  single-cycle pulse; clears the last-read buffer.
- s_word_address  out  ADDR_WIDTH  address to the flash controller, registered.
- s_rstrb  out  1  read strobe to the flash controller.
- s_rdata  in  32  flash read data; valid in the first cycle s_rbusy=0 after the strobe.
- s_rbusy  in  1  flash busy; the controller raises it the cycle after s_rstrb.

## Operation
- Per requester N: pend[N] flag and addr[N] register. mN_rstrb=1 sets pend[N] and captures the address. mN_rbusy = pend[N].
- A strobe from a requester whose pend is already set is a protocol violation. It overwrites addr[N], and set wins over a same-edge clear.
- Last-read buffer: buf_valid, buf_addr, buf_data. Reset value is buf_valid=0.
- Round-robin state: last_grant register, reset value 1, so m0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, no pend: stay in IDLE.
- IDLE, one pend: that requester is the winner.
- IDLE, both pend: the requester that is not last_grant wins.
- IDLE, winner's address hits the buffer (USE_BUF=1, buf_valid, addr==buf_addr): at this edge mN_rdata<=buf_data, clear pend[winner], last_grant<=winner, stay in IDLE.
- IDLE, winner misses the buffer: grant<=winner, s_word_address<=addr[winner], last_grant<=winner, go to ISSUE.
- ISSUE: s_rstrb=1 for exactly this cycle, then go to WAIT.
- WAIT: hold while s_rbusy=1. When s_rbusy=0: mN_rdata<=s_rdata for the granted N, clear pend[grant], and go to IDLE. On the same edge, buffer fill: buf_addr<=s_word_address, buf_data<=s_rdata, buf_valid<=1.
- inval clears buf_valid. If inval coincides with a fill, inval wins (buf_valid=0). inval during a hit edge: the hit is still served from the old buffer contents.
- mN_rdata holds its value until that requester's next completion. The other requester's completion does not change it.

## Timing
- Reset values (asynchronous, while resetn=0): state=IDLE, pend=0, m0_rbusy=m1_rbusy=0, m0_rdata=m1_rdata=0, s_rstrb=0, s_word_address=0, buf_valid=0, last_grant=1.
- s_rstrb is decoded from state==ISSUE only, so it is never high in IDLE or WAIT.
- Miss, no contention, strobe at cycle T:
  - pend set and rbusy=1 from T+1.
  - IDLE grants at the T+1 edge; s_rstrb=1 in T+2.
  - WAIT from T+3. If the flash drops busy in cycle T+3+k, rbusy=0 and data valid from T+4+k.
- Hit, strobe at cycle T: rbusy=1 for T+1 only; data valid and rbusy=0 from T+2.
- A losing requester waits for the full winner transaction plus one IDLE cycle.
- Reset mid-transaction (ISSUE or WAIT): abandon the request. The flash controller is reset by the same resetn. No data is delivered and no buffer fill occurs.
- Address widths match on all ports; no truncation or extension.

## Test plan
- m0 strobe addr 0x00010; flash busy 5 cycles, returns 0xDEADBEEF -> s_rstrb once in T+2 with s_word_address=0x00010; m0_rdata=0xDEADBEEF as m0_rbusy falls; m1_rdata stays 0.
- Reset, then m0 (0x00100) and m1 (0x00200) strobe in the same cycle -> two s_rstrb pulses, 0x00100 first then 0x00200; m1_rbusy stays high until its own completion.
- After a m0 grant, both requesters strobe again with new addresses (no hit) -> m1 is served before m0.
- m1 rereads 0x00200 immediately after a completed read of 0x00200 -> no s_rstrb; m1_rbusy high for exactly one cycle; same data returned.
- inval pulse, then m1 rereads 0x00200 -> a flash access occurs (s_rstrb with 0x00200). Separately, inval on the same edge as a fill -> the next read of that address misses.
- resetn low during WAIT -> all outputs 0 immediately and no data delivered. After release, m0 read of 0x00004 completes normally with USE_BUF hit disabled (buf_valid=0).
